// File: rtl/alu_arb.sv
// Two-port arbiter in front of a shared combinational ALU.
// Each operation takes one EXEC cycle and one DONE cycle, and the two
// ports take turns when both are asking.
`timescale 1ns/1ps

module alu_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [4:0]  op0,
    input  logic [4:0]  op1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        bad_op,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 5;

    localparam logic [OP_W-1:0] OP_NOP = 5'h00;
    localparam logic [OP_W-1:0] OP_MAX = 5'h06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // last is 1 when port 1 won the most recent arbitration
    logic              last;
    logic              last_nxt;
    logic              port;
    logic              port_nxt;
    logic              bad;
    logic              bad_nxt;
    logic              sel;
    logic [OP_W-1:0]   sel_op;

    logic [DATA_W-1:0] alu_a_nxt;
    logic [DATA_W-1:0] alu_b_nxt;
    logic [OP_W-1:0]   alu_op_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic              gnt0_nxt;
    logic              gnt1_nxt;
    logic              done0_nxt;
    logic              done1_nxt;
    logic              bad_op_nxt;
    logic              busy_nxt;

    // State and registered outputs; reset wins over everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            port   <= 1'b0;
            bad    <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= OP_NOP;
            result <= '0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            bad_op <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            port   <= port_nxt;
            bad    <= bad_nxt;
            alu_a  <= alu_a_nxt;
            alu_b  <= alu_b_nxt;
            alu_op <= alu_op_nxt;
            result <= result_nxt;
            gnt0   <= gnt0_nxt;
            gnt1   <= gnt1_nxt;
            done0  <= done0_nxt;
            done1  <= done1_nxt;
            bad_op <= bad_op_nxt;
            busy   <= busy_nxt;
        end
    end

    // Arbitration, next state and next output values
    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        port_nxt   = port;
        bad_nxt    = bad;
        sel        = 1'b0;
        sel_op     = op0;
        alu_a_nxt  = alu_a;
        alu_b_nxt  = alu_b;
        alu_op_nxt = alu_op;
        result_nxt = result;
        gnt0_nxt   = 1'b0;
        gnt1_nxt   = 1'b0;
        done0_nxt  = 1'b0;
        done1_nxt  = 1'b0;
        bad_op_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    sel        = (req0 && req1) ? ~last : req1;
                    sel_op     = sel ? op1 : op0;
                    state_nxt  = EXEC;
                    last_nxt   = sel;
                    port_nxt   = sel;
                    bad_nxt    = (sel_op > OP_MAX);
                    alu_a_nxt  = sel ? a1 : a0;
                    alu_b_nxt  = sel ? b1 : b0;
                    alu_op_nxt = (sel_op > OP_MAX) ? OP_NOP : sel_op;
                    gnt0_nxt   = ~sel;
                    gnt1_nxt   = sel;
                end
            end
            EXEC: begin
                state_nxt  = DONE;
                result_nxt = (bad || (alu_op == OP_NOP)) ? DATA_W'(0) : alu_out;
                done0_nxt  = ~port;
                done1_nxt  = port;
                bad_op_nxt = bad;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
